// File: rtl/inst_issue_scoreboard.sv
// Single-entry instruction issue stage with a register scoreboard.
// One instruction is held. It is presented downstream only once none of its
// operands or its destination are pending in the scoreboard.
module inst_issue_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    input  logic [31:0]            in_inst_i,
    output logic                   in_ready_o,
    output logic                   issue_valid_o,
    output logic [31:0]            issue_inst_o,
    input  logic                   issue_ready_i,
    input  logic                   wb_valid_i,
    input  logic [4:0]             wb_rd_i,
    input  logic                   flush_i,
    output logic                   illegal_o,
    output logic                   wb_err_o,
    output logic [31:0]            busy_regs_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {EMPTY, HAZARD, PRESENT} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            inst_q, inst_d;
    logic [31:0]            busy_q, busy_d;
    logic                   illegal_q, illegal_d;
    logic                   wb_err_q, wb_err_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // Operand class of an opcode: {legal, uses rs1, uses rs2, uses rd}.
    function automatic logic [3:0] decode(input logic [6:0] op);
        logic [3:0] cls;
        case (op)
            7'b0110011: cls = 4'b1111;
            7'b0010011: cls = 4'b1101;
            7'b0100011,
            7'b1100011: cls = 4'b1110;
            7'b0010111,
            7'b1101111: cls = 4'b1001;
            7'b0001011: cls = 4'b1000;
            default:    cls = 4'b0000;
        endcase
        return cls;
    endfunction

    // True when any used, nonzero register of the instruction is pending.
    function automatic logic hazard_check(input logic [3:0]  cls,
                                          input logic [4:0]  rs1,
                                          input logic [4:0]  rs2,
                                          input logic [4:0]  rd,
                                          input logic [31:0] busy);
        return (cls[2] && (rs1 != 5'd0) && busy[rs1]) ||
               (cls[1] && (rs2 != 5'd0) && busy[rs2]) ||
               (cls[0] && (rd  != 5'd0) && busy[rd]);
    endfunction

    logic [3:0] held_cls, in_cls;
    logic [4:0] held_rd;
    logic       handshake, accept, issue_set;
    logic       held_hazard, in_hazard;

    assign held_cls      = decode(inst_q[6:0]);
    assign in_cls        = decode(in_inst_i[6:0]);
    assign held_rd       = inst_q[11:7];
    assign issue_valid_o = (state_q == PRESENT);
    assign handshake     = issue_valid_o && issue_ready_i;
    assign in_ready_o    = !flush_i && ((state_q == EMPTY) || handshake);
    assign accept        = in_valid_i && in_ready_o;
    assign issue_set     = handshake && !flush_i && held_cls[0] && (held_rd != 5'd0);

    // Next scoreboard: writeback clears first, then an issuing rd sets (set wins).
    always_comb begin
        busy_d   = busy_q;
        wb_err_d = 1'b0;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (wb_valid_i && (wb_rd_i != 5'd0)) begin
                if (busy_q[wb_rd_i]) begin
                    busy_d[wb_rd_i] = 1'b0;
                end else if (!(issue_set && (held_rd == wb_rd_i))) begin
                    wb_err_d = 1'b1;
                end
            end
            if (issue_set) begin
                busy_d[held_rd] = 1'b1;
            end
        end
    end

    // Hazards are judged against the next scoreboard so writebacks bypass.
    assign held_hazard = hazard_check(held_cls, inst_q[19:15], inst_q[24:20], inst_q[11:7], busy_d);
    assign in_hazard   = hazard_check(in_cls, in_inst_i[19:15], in_inst_i[24:20], in_inst_i[11:7], busy_d);

    // Hold-register state transitions, illegal drop and stall counting.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        illegal_d = 1'b0;
        stall_d   = stall_q;
        if ((state_q == HAZARD) && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            if (handshake) begin
                state_d = EMPTY;
            end
            if ((state_q == HAZARD) && !held_hazard) begin
                state_d = PRESENT;
            end
            if (accept) begin
                if (in_cls[3]) begin
                    inst_d  = in_inst_i;
                    state_d = in_hazard ? HAZARD : PRESENT;
                end else begin
                    illegal_d = 1'b1;
                end
            end
        end
    end

    // All state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            inst_q    <= '0;
            busy_q    <= '0;
            illegal_q <= 1'b0;
            wb_err_q  <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
            wb_err_q  <= wb_err_d;
            stall_q   <= stall_d;
        end
    end

    assign issue_inst_o = inst_q;
    assign busy_regs_o  = busy_q;
    assign illegal_o    = illegal_q;
    assign wb_err_o     = wb_err_q;
    assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_inst_issue_scoreboard.sv
// Self-checking bench for inst_issue_scoreboard: directed scenarios followed
// by random traffic, all compared against a behavioural model every cycle.
module tb_inst_issue_scoreboard;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i;
    logic [31:0]   in_inst_i;
    logic          in_ready_o;
    logic          issue_valid_o;
    logic [31:0]   issue_inst_o;
    logic          issue_ready_i;
    logic          wb_valid_i;
    logic [4:0]    wb_rd_i;
    logic          flush_i;
    logic          illegal_o;
    logic          wb_err_o;
    logic [31:0]   busy_regs_o;
    logic [CW-1:0] stall_cnt_o;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: held instruction, whether it is visible downstream,
    // pending register set, pulse expectations and stall count.
    bit          mHeld;
    bit          mVisible;
    logic [31:0] mInst;
    logic [31:0] mBusy;
    bit          mIll;
    bit          mErr;
    int          mStall;

    logic [31:0] saved;

    inst_issue_scoreboard #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_inst_i(in_inst_i), .in_ready_o(in_ready_o),
        .issue_valid_o(issue_valid_o), .issue_inst_o(issue_inst_o), .issue_ready_i(issue_ready_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
        .illegal_o(illegal_o), .wb_err_o(wb_err_o),
        .busy_regs_o(busy_regs_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic bit isLegal(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h23, 7'h63, 7'h17, 7'h6F, 7'h0B};
    endfunction

    function automatic bit writesRd(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h17, 7'h6F};
    endfunction

    function automatic bit modelHazard(input logic [31:0] inst, input logic [31:0] busy);
        int regs[$];
        logic [6:0] op = inst[6:0];
        if (op inside {7'h33, 7'h13, 7'h23, 7'h63}) regs.push_back(int'(inst[19:15]));
        if (op inside {7'h33, 7'h23, 7'h63})        regs.push_back(int'(inst[24:20]));
        if (writesRd(op))                           regs.push_back(int'(inst[11:7]));
        foreach (regs[i]) begin
            if (regs[i] != 0 && busy[regs[i]]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        bit expReady;
        expReady = !flush_i && (!mHeld || (mVisible && issue_ready_i));
        checkOutput({tag, "/in_ready"},    32'(in_ready_o),    32'(expReady));
        checkOutput({tag, "/issue_valid"}, 32'(issue_valid_o), 32'(mHeld && mVisible));
        checkOutput({tag, "/issue_inst"},  issue_inst_o,       mInst);
        checkOutput({tag, "/busy"},        busy_regs_o,        mBusy);
        checkOutput({tag, "/illegal"},     32'(illegal_o),     32'(mIll));
        checkOutput({tag, "/wb_err"},      32'(wb_err_o),      32'(mErr));
        checkOutput({tag, "/stall"},       32'(stall_cnt_o),   32'(mStall));
    endtask

    task automatic modelReset();
        mHeld = 0; mVisible = 0; mInst = '0; mBusy = '0;
        mIll = 0; mErr = 0; mStall = 0;
    endtask

    task automatic modelStep();
        bit          hs, rdyNow;
        logic [31:0] nb;
        int          setRd;
        if (mHeld && !mVisible && mStall < (1 << CW) - 1) mStall++;
        mIll = 0;
        mErr = 0;
        if (flush_i) begin
            mHeld = 0; mVisible = 0; mBusy = '0;
            return;
        end
        hs     = mHeld && mVisible && issue_ready_i;
        rdyNow = !mHeld || hs;
        nb     = mBusy;
        setRd  = (hs && writesRd(mInst[6:0])) ? int'(mInst[11:7]) : 0;
        if (wb_valid_i && wb_rd_i != 5'd0) begin
            if (mBusy[wb_rd_i]) nb[wb_rd_i] = 1'b0;
            else if (setRd != int'(wb_rd_i)) mErr = 1;
        end
        if (setRd != 0) nb[setRd] = 1'b1;
        if (hs) begin mHeld = 0; mVisible = 0; end
        if (mHeld && !mVisible) mVisible = !modelHazard(mInst, nb);
        if (in_valid_i && rdyNow) begin
            if (isLegal(in_inst_i[6:0])) begin
                mHeld = 1; mInst = in_inst_i; mVisible = !modelHazard(in_inst_i, nb);
            end else begin
                mIll = 1;
            end
        end
        mBusy = nb;
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] inst, input bit rdy,
                                 input bit wbv, input logic [4:0] wbrd, input bit fl,
                                 input string tag);
        in_valid_i = v; in_inst_i = inst; issue_ready_i = rdy;
        wb_valid_i = wbv; wb_rd_i = wbrd; flush_i = fl;
        #1;
        checkAll(tag);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        in_valid_i = 0; in_inst_i = '0; issue_ready_i = 0;
        wb_valid_i = 0; wb_rd_i = '0; flush_i = 0;
    endtask

    initial begin
        logic [6:0]  ops [8] = '{7'h33, 7'h13, 7'h23, 7'h63, 7'h17, 7'h6F, 7'h0B, 7'h7F};
        logic [31:0] ri;
        idleInputs();
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("reset");
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_ready", 32'(in_ready_o), 32'd1);

        // ADDI x5,x0,1: visible the cycle after accept, then marks x5 busy.
        applyStimulus(1, 32'h00100293, 0, 0, 0, 0, "addi_acc");
        checkOutput("addi_valid", 32'(issue_valid_o), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0, "addi_hs");
        checkOutput("addi_busy", busy_regs_o, 32'h00000020);

        // ADD x6,x5,x1 waits on x5, counts stalls, releases on writeback of x5.
        applyStimulus(1, 32'h00128333, 0, 0, 0, 0, "add_acc");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, "add_hz");
        checkOutput("add_stall3", 32'(stall_cnt_o), 32'd3);
        checkOutput("add_not_valid", 32'(issue_valid_o), 32'd0);
        applyStimulus(0, 0, 0, 1, 5'd5, 0, "add_wb5");
        checkOutput("add_valid", 32'(issue_valid_o), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0, "add_hs");
        checkOutput("add_busy", busy_regs_o, 32'h00000040);
        applyStimulus(0, 0, 0, 1, 5'd6, 0, "wb6");

        // Unsupported opcode is dropped with a single illegal pulse.
        saved = busy_regs_o;
        applyStimulus(1, 32'h0000007F, 0, 0, 0, 0, "ill_acc");
        checkOutput("ill_pulse", 32'(illegal_o), 32'd1);
        checkOutput("ill_no_valid", 32'(issue_valid_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, "ill_after");
        checkOutput("ill_pulse_end", 32'(illegal_o), 32'd0);
        checkOutput("ill_busy", busy_regs_o, saved);

        // Writeback to idle x9 errors; writeback racing an issue of x7 does not.
        applyStimulus(0, 0, 0, 1, 5'd9, 0, "wb9");
        checkOutput("wb9_err", 32'(wb_err_o), 32'd1);
        applyStimulus(1, 32'h00000393, 0, 0, 0, 0, "x7_acc");
        checkOutput("wb9_err_end", 32'(wb_err_o), 32'd0);
        applyStimulus(0, 0, 1, 1, 5'd7, 0, "x7_hs_wb");
        checkOutput("x7_busy", busy_regs_o, 32'h00000080);
        checkOutput("x7_no_err", 32'(wb_err_o), 32'd0);
        applyStimulus(0, 0, 0, 1, 5'd7, 0, "wb7");

        // Build busy=0xF0, park ADD x8,x4,x5 in hazard, then flush.
        for (int r = 4; r < 8; r++) begin
            applyStimulus(1, (r << 7) | 32'h13, 0, 0, 0, 0, "fill_acc");
            applyStimulus(0, 0, 1, 0, 0, 0, "fill_hs");
        end
        checkOutput("fill_busy", busy_regs_o, 32'h000000F0);
        applyStimulus(1, 32'h00520433, 0, 0, 0, 0, "fl_acc");
        applyStimulus(0, 0, 0, 0, 0, 0, "fl_hz");
        applyStimulus(1, 32'h00000293, 1, 1, 5'd4, 1, "flush");
        idleInputs();
        #1;
        checkOutput("fl_busy", busy_regs_o, 32'h0);
        checkOutput("fl_valid", 32'(issue_valid_o), 32'd0);
        checkOutput("fl_ready", 32'(in_ready_o), 32'd1);

        // Backpressure keeps the presented word stable and blocks intake.
        applyStimulus(1, 32'h00A00193, 0, 0, 0, 0, "bp_acc");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h00000213, 0, 0, 0, 0, "bp_hold");
            checkOutput("bp_inst", issue_inst_o, 32'h00A00193);
            checkOutput("bp_valid", 32'(issue_valid_o), 32'd1);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, "bp_hs");
        applyStimulus(0, 0, 0, 1, 5'd3, 0, "wb3");

        // Long hazard drives the stall counter into saturation.
        applyStimulus(1, 32'h00000093, 0, 0, 0, 0, "sat_x1");
        applyStimulus(0, 0, 1, 0, 0, 0, "sat_x1_hs");
        applyStimulus(1, 32'h00008113, 0, 0, 0, 0, "sat_acc");
        for (int i = 0; i < 70; i++) applyStimulus(0, 0, 0, 0, 0, 0, "sat_hz");
        checkOutput("sat_max", 32'(stall_cnt_o), 32'h3F);
        applyStimulus(0, 0, 0, 0, 0, 0, "sat_hold");
        checkOutput("sat_stays", 32'(stall_cnt_o), 32'h3F);
        applyStimulus(0, 0, 0, 1, 5'd1, 0, "sat_wb1");
        applyStimulus(0, 0, 1, 0, 0, 0, "sat_hs");
        applyStimulus(0, 0, 0, 1, 5'd2, 0, "sat_wb2");

        // Reset mid-operation drops the held instruction without issuing it.
        applyStimulus(1, 32'h00000513, 0, 0, 0, 0, "rst_acc");
        idleInputs();
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_valid", 32'(issue_valid_o), 32'd0);
        checkOutput("rst_inst", issue_inst_o, 32'h0);
        checkOutput("rst_stall", 32'(stall_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 0, 0, 0, "rst_after");

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            ri        = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 7)];
            ri[11:7]  = 5'($urandom_range(0, 7));
            ri[19:15] = 5'($urandom_range(0, 7));
            ri[24:20] = 5'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 9) < 6, ri, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
                          $urandom_range(0, 99) < 3, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_issue_scoreboard.md
INST_ISSUE_SCOREBOARD -- requirements
Module: inst_issue_scoreboard

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the saturating hazard-stall counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid_i  input  1  upstream instruction valid.
REQ-005 SHALL have port in_inst_i  input  32  raw RISC-V instruction word: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
REQ-006 SHALL have port in_ready_o  output  1  block can accept an instruction.
REQ-007 SHALL have port issue_valid_o  output  1  held instruction is hazard-free and presented downstream.
REQ-008 SHALL have port issue_inst_o  output  32  held instruction word.
REQ-009 SHALL have port issue_ready_i  input  1  downstream accepts the instruction.
REQ-010 SHALL have port wb_valid_i  input  1  writeback completes.
REQ-011 SHALL have port wb_rd_i  input  5  register being written back.
REQ-012 SHALL have port flush_i  input  1  discard held instruction and clear all pending registers.
REQ-013 SHALL have port illegal_o  output  1  one-cycle pulse: unsupported opcode dropped.
REQ-014 SHALL have port wb_err_o  output  1  one-cycle pulse: writeback to a non-pending register.
REQ-015 SHALL have port busy_regs_o  output  32  scoreboard, bit n = xn pending.
REQ-016 SHALL have port stall_cnt_o  output  STALL_CNT_W  cycles spent in HAZARD, saturating.

Function
REQ-017 SHALL classify opcodes as follows: r_type 0110011 (rs1, rs2, rd); i_type 0010011 (rs1, rd); s_type 0100011 and b_type 1100011 (rs1, rs2); u_type 0010111 and j_type 1101111 (rd only); custom_0 0001011 (no operands); any other opcode is illegal.
REQ-018 SHALL hold one instruction in a hold register, with FSM states EMPTY, HAZARD and PRESENT.
REQ-019 SHALL assert in_ready_o = (state==EMPTY) or (issue_valid_o and issue_ready_i), and accept an instruction on in_valid_i and in_ready_o.
REQ-020 SHALL drop an accepted illegal instruction, pulse illegal_o in the following cycle, and leave the state EMPTY or advance it per any concurrent issue.
REQ-021 SHALL detect a hazard when any used source, or rd, is nonzero and its scoreboard bit is set after applying the same-cycle writeback clear (writeback bypass).
REQ-022 SHALL load an accepted legal instruction and go to HAZARD if a hazard exists, otherwise to PRESENT, with hazard evaluated on the next cycle; minimum latency is accept in cycle N, issue_valid_o in cycle N+1.
REQ-023 SHALL move from HAZARD to PRESENT in the cycle after the hazard clears.
REQ-024 SHALL assert issue_valid_o only in PRESENT, and once asserted hold issue_valid_o and issue_inst_o stable until handshake or flush.
REQ-025 SHALL, on handshake with a used rd≠0, set busy[rd] and go to EMPTY, or go to PRESENT/HAZARD if a new instruction is accepted in the same cycle.
REQ-026 SHALL clear busy[wb_rd_i] on wb_valid_i when that bit is set; otherwise it SHALL pulse wb_err_o in the following cycle.
REQ-027 SHALL let the set win when issue sets and writeback clears the same rd in one cycle, with no wb_err_o.
REQ-028 SHALL never set busy[0], and SHALL treat a writeback to x0 as ignored without an error.
REQ-029 SHALL increment stall_cnt_o each cycle in HAZARD, saturate at all-ones, and never wrap.
REQ-030 SHALL make flush_i dominant: next cycle state EMPTY, busy cleared, in_ready_o=0 during the flush cycle, no accept, writeback ignored, stall_cnt_o kept.

Reset
REQ-031 SHALL, while rst_n=0 (asynchronous), force state EMPTY, busy_regs_o=0, issue_valid_o=0, issue_inst_o=0, illegal_o=0, wb_err_o=0 and stall_cnt_o=0; in_ready_o SHALL be 1 after release.
REQ-032 SHALL discard a held instruction on reset mid-operation without issuing it.

Verification
REQ-033 SHALL verify: ADDI x5,x0,1 (0x00100293) accepted cycle 0 -> issue_valid_o cycle 1; handshake -> busy_regs_o=0x00000020.
REQ-034 SHALL verify: with x5 busy, ADD x6,x5,x1 held -> HAZARD, stall_cnt_o counts 3 over 3 cycles; wb_rd_i=5 -> issue_valid_o next cycle.
REQ-035 SHALL verify: opcode 0x7F -> illegal_o single pulse, issue_valid_o stays 0, busy_regs_o unchanged.
REQ-036 SHALL verify: wb_rd_i=9 with x9 not busy -> wb_err_o pulse; same-cycle issue of rd=7 plus wb rd=7 -> busy[7]=1, no error.
REQ-037 SHALL verify: flush_i while in HAZARD with busy=0x000000F0 -> next cycle EMPTY, busy_regs_o=0, in_ready_o=1.
REQ-038 SHALL verify: issue_ready_i held 0 for 5 cycles in PRESENT -> issue_inst_o stable, in_ready_o=0; stall_cnt_o at 0xFFFF stays 0xFFFF.
